// File: rtl/cpu_pkg.sv
// Shared fetch-stage types and instruction field constants.
// Imported by the fetch unit and its helpers.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD,
        HALTED
    } fetch_state_t;

    localparam logic [5:0] HALT_OPCODE = 6'b111111;
    localparam int OPCODE_HI = 31;
    localparam int OPCODE_LO = 26;

    function automatic logic is_misaligned(input logic [1:0] lo);
        return lo != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_timeout_counter.sv
// Up-counter bounding how long a memory request may stay unanswered.
// tc flags the last permitted wait cycle (count == TIMEOUT-1).
module fetch_timeout_counter #(
    parameter int TIMEOUT = 16,
    parameter int W       = $clog2(TIMEOUT) + 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         tc
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + W'(1);
        end
    end

    assign tc = (cnt == W'(TIMEOUT - 1));

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: request/ack imem read, instruction register,
// halt/misalign/timeout detection and a retired-fetch counter.
module instr_fetch_unit #(
    parameter int         ADDR_W      = 32,
    parameter int         DATA_W      = 32,
    parameter logic [5:0] HALT_OPCODE = 6'b111111,
    parameter int         TIMEOUT     = 16,
    parameter int         CNT_W       = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              pc_valid,
    input  logic              cont,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] instr_out,
    output logic              instr_valid,
    input  logic              decode_ready,
    output logic              halt,
    output logic              fetch_err,
    output logic [CNT_W-1:0]  fetch_count
);

    import cpu_pkg::*;

    localparam int TW = $clog2(TIMEOUT) + 1;

    fetch_state_t  state;
    logic [TW-1:0] to_cnt;
    logic          to_tc;
    logic          to_clr;
    logic          to_en;
    logic          is_halt;

    // Timer runs only while a request is outstanding; any other state rearms it.
    assign to_clr  = (state != REQ);
    assign to_en   = (state == REQ) && !imem_ack;
    assign is_halt = (imem_rdata[OPCODE_HI:OPCODE_LO] == HALT_OPCODE);

    fetch_timeout_counter #(
        .TIMEOUT (TIMEOUT),
        .W       (TW)
    ) u_timeout (
        .clk   (clk),
        .reset (reset),
        .clr   (to_clr),
        .en    (to_en),
        .cnt   (to_cnt),
        .tc    (to_tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            imem_req    <= 1'b0;
            imem_addr   <= '0;
            instr_out   <= '0;
            instr_valid <= 1'b0;
            halt        <= 1'b0;
            fetch_err   <= 1'b0;
            fetch_count <= '0;
        end else begin
            case (state)
                IDLE, HOLD: begin
                    if (state == IDLE || decode_ready) begin
                        if (state == HOLD) begin
                            fetch_count <= fetch_count + CNT_W'(1);
                            instr_valid <= 1'b0;
                            state       <= IDLE;
                        end
                        if (pc_valid) begin
                            if (is_misaligned(pc_in[1:0])) begin
                                fetch_err <= 1'b1;
                                halt      <= 1'b1;
                                state     <= HALTED;
                            end else begin
                                imem_addr <= pc_in;
                                imem_req  <= 1'b1;
                                state     <= REQ;
                            end
                        end
                    end
                end
                REQ: begin
                    // A late ack still beats the timeout on the same edge.
                    if (imem_ack) begin
                        imem_req  <= 1'b0;
                        instr_out <= imem_rdata;
                        if (is_halt) begin
                            halt  <= 1'b1;
                            state <= HALTED;
                        end else begin
                            instr_valid <= 1'b1;
                            state       <= HOLD;
                        end
                    end else if (to_tc) begin
                        imem_req  <= 1'b0;
                        fetch_err <= 1'b1;
                        halt      <= 1'b1;
                        state     <= HALTED;
                    end
                end
                HALTED: begin
                    if (cont) begin
                        halt      <= 1'b0;
                        fetch_err <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
